// File: rtl/store_drain_buffer.sv
// Store drain buffer: absorbs up to N_WAY retired stores per cycle and issues
// them one at a time as word-aligned, byte-enabled data cache writes.

module sdb_lane #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data,
  input  logic [1:0]        size,
  output logic [XLEN-1:0]   wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic [XLEN/8-1:0] wr_be,
  output logic              misalign
);
  localparam int BW = XLEN / 8;

  logic [1:0] off;
  logic [3:0] be4;

  // Misaligned stores keep the shifted enables, truncated to the word.
  always_comb begin
    off      = addr[1:0];
    wr_addr  = {addr[XLEN-1:2], 2'b00};
    wr_data  = data;
    be4      = 4'hF;
    misalign = 1'b0;
    case (size)
      2'd0: begin
        be4     = 4'b0001 << off;
        wr_data = XLEN'(data[7:0]) << {off, 3'b000};
      end
      2'd1: begin
        be4      = 4'b0011 << off;
        wr_data  = XLEN'(data[15:0]) << {off, 3'b000};
        misalign = off[0];
      end
      default: misalign = |off;
    endcase
    wr_be = BW'(be4);
  end
endmodule

module store_drain_buffer #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 4,
  parameter int N_SQ  = 8,
  parameter int XLEN  = 32,
  localparam int SQ_W = $clog2(N_SQ) + 1,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int BW   = XLEN / 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WAY-1:0]            ret_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]  ret_addr,
  input  logic [N_WAY-1:0][XLEN-1:0]  ret_data,
  input  logic [N_WAY-1:0][1:0]       ret_size,
  input  logic [N_WAY-1:0][SQ_W-1:0]  ret_store_pos,
  output logic [CW-1:0]               free_slots,
  output logic                        dc_req_valid,
  input  logic                        dc_req_ready,
  output logic [XLEN-1:0]             dc_addr,
  output logic [XLEN-1:0]             dc_data,
  output logic [BW-1:0]               dc_be,
  input  logic                        dc_wr_ack,
  output logic                        cmp_valid,
  output logic [SQ_W-1:0]             cmp_store_pos,
  output logic                        misalign_err,
  output logic                        overflow_err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [BW-1:0]   be;
    logic [SQ_W-1:0] pos;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d, free_q, free_d;
  logic            cmp_valid_q, cmp_valid_d;
  logic [SQ_W-1:0] cmp_pos_q, cmp_pos_d;
  logic            mis_q, mis_d, ovf_q, ovf_d;

  ent_t [N_WAY-1:0]  lane_ent;
  logic [N_WAY-1:0]  lane_mis;

  for (genvar l = 0; l < N_WAY; l++) begin : g_lane
    sdb_lane #(.XLEN(XLEN)) u_lane (
      .addr     (ret_addr[l]),
      .data     (ret_data[l]),
      .size     (ret_size[l]),
      .wr_addr  (lane_ent[l].addr),
      .wr_data  (lane_ent[l].data),
      .wr_be    (lane_ent[l].be),
      .misalign (lane_mis[l])
    );
    assign lane_ent[l].pos = ret_store_pos[l];
  end

  logic          pop;
  logic [CW-1:0] space, n_push;
  logic [PW-1:0] widx;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    head_d      = head_q;
    cmp_valid_d = 1'b0;
    cmp_pos_d   = '0;
    mis_d       = mis_q;
    ovf_d       = ovf_q;
    pop         = 1'b0;
    widx        = tail_q;

    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_REQ;
      S_REQ:  if (dc_req_ready) state_d = S_WAIT;
      S_WAIT: if (dc_wr_ack) begin
        pop         = 1'b1;
        cmp_valid_d = 1'b1;
        cmp_pos_d   = mem_q[head_q].pos;
        state_d     = (count_q > CW'(1)) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) head_d = head_q + PW'(1);

    // A slot freed by this cycle's pop is usable by this cycle's lanes.
    space  = CW'(DEPTH) - count_q + CW'(pop);
    n_push = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_valid[i]) begin
        if (lane_mis[i]) mis_d = 1'b1;
        if (n_push < space) begin
          widx        = tail_q + n_push[PW-1:0];
          mem_d[widx] = lane_ent[i];
          n_push      = n_push + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    tail_d  = tail_q + n_push[PW-1:0];
    count_d = count_q - CW'(pop) + n_push;
    free_d  = CW'(DEPTH) - count_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      free_q      <= CW'(DEPTH);
      cmp_valid_q <= 1'b0;
      cmp_pos_q   <= '0;
      mis_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      free_q      <= free_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_pos_q   <= cmp_pos_d;
      mis_q       <= mis_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clock) mem_q <= mem_d;

  assign free_slots    = free_q;
  assign dc_req_valid  = (state_q == S_REQ);
  assign dc_addr       = dc_req_valid ? mem_q[head_q].addr : '0;
  assign dc_data       = dc_req_valid ? mem_q[head_q].data : '0;
  assign dc_be         = dc_req_valid ? mem_q[head_q].be   : '0;
  assign cmp_valid     = cmp_valid_q;
  assign cmp_store_pos = cmp_pos_q;
  assign misalign_err  = mis_q;
  assign overflow_err  = ovf_q;
endmodule

// File: tb/tb_store_drain_buffer.sv
// Scoreboarded bench for store_drain_buffer: directed scenarios plus random
// retire/ready/ack traffic against a byte-level FIFO reference model.

module tb_store_drain_buffer;
  localparam int N_WAY = 2;
  localparam int DEPTH = 4;
  localparam int N_SQ  = 8;
  localparam int XLEN  = 32;
  localparam int SQ_W  = $clog2(N_SQ) + 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [N_WAY-1:0]           ret_valid;
  logic [N_WAY-1:0][XLEN-1:0] ret_addr;
  logic [N_WAY-1:0][XLEN-1:0] ret_data;
  logic [N_WAY-1:0][1:0]      ret_size;
  logic [N_WAY-1:0][SQ_W-1:0] ret_store_pos;
  logic [CW-1:0]              free_slots;
  logic                       dc_req_valid, dc_req_ready;
  logic [XLEN-1:0]            dc_addr, dc_data;
  logic [XLEN/8-1:0]          dc_be;
  logic                       dc_wr_ack, cmp_valid;
  logic [SQ_W-1:0]            cmp_store_pos;
  logic                       misalign_err, overflow_err;

  store_drain_buffer #(.N_WAY(N_WAY), .DEPTH(DEPTH), .N_SQ(N_SQ), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_addr(ret_addr),
    .ret_data(ret_data), .ret_size(ret_size), .ret_store_pos(ret_store_pos),
    .free_slots(free_slots), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_be(dc_be), .dc_wr_ack(dc_wr_ack),
    .cmp_valid(cmp_valid), .cmp_store_pos(cmp_store_pos),
    .misalign_err(misalign_err), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  pos;
  } exp_t;

  exp_t exp_req[$];
  exp_t exp_cmp[$];
  int   checks = 0;
  int   errors = 0;
  int   occ = 0;
  bit   outstanding = 0;
  bit   exp_mis = 0, exp_ovf = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Byte-level view: the store's bytes land on lanes off..off+n-1 of the word.
  function automatic exp_t xform(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] s, input logic [3:0] p);
    exp_t e;
    int off, nb;
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off = (nb == 4) ? 0 : int'(a[1:0]);
    e.addr = a & 32'hFFFF_FFFC;
    e.data = '0;
    e.be   = '0;
    e.pos  = p;
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + nb) begin
        e.be[k] = 1'b1;
        e.data[8*k +: 8] = d[8*(k-off) +: 8];
      end
    return e;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [3:0] p);
    ret_valid[l] = 1'b1;
    ret_addr[l] = a;
    ret_data[l] = d;
    ret_size[l] = s;
    ret_store_pos[l] = p;
  endtask

  // One clock: drive, advance the model across the coming edge, then check.
  task automatic tick(input logic rdy, input logic ack);
    bit pop, acc;
    int space, adm;
    dc_req_ready = rdy;
    dc_wr_ack = ack;
    pop = outstanding && ack;
    acc = dc_req_valid && rdy;
    space = DEPTH - occ + int'(pop);
    adm = 0;
    for (int i = 0; i < N_WAY; i++)
      if (ret_valid[i]) begin
        if (is_mis(ret_addr[i], ret_size[i])) exp_mis = 1;
        if (adm < space) begin
          exp_req.push_back(xform(ret_addr[i], ret_data[i], ret_size[i], ret_store_pos[i]));
          exp_cmp.push_back(xform(ret_addr[i], ret_data[i], ret_size[i], ret_store_pos[i]));
          adm++;
        end else exp_ovf = 1;
      end
    occ = occ - int'(pop) + adm;
    outstanding = (outstanding && !pop) || acc;
    @(posedge clock); #1;
    ret_valid = '0;
    dc_wr_ack = 1'b0;
    chk("free_slots", 64'(free_slots), 64'(DEPTH - occ));
    chk("misalign_err", 64'(misalign_err), 64'(exp_mis));
    chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
    chk("cmp_valid", 64'(cmp_valid), 64'(pop));
    if (!pop) chk("cmp_pos_idle", 64'(cmp_store_pos), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ret_valid = '0;
    dc_req_ready = 1'b0;
    dc_wr_ack = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_req.delete();
    exp_cmp.delete();
    occ = 0;
    outstanding = 0;
    exp_mis = 0;
    exp_ovf = 0;
    chk("rst_free", 64'(free_slots), 64'(DEPTH));
    chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_dc_fields", {dc_addr, dc_data[27:0], dc_be}, 64'd0);
    chk("rst_cmp", {cmp_valid, cmp_store_pos}, 64'd0);
    chk("rst_errs", {misalign_err, overflow_err}, 64'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (occ > 0 || outstanding); n++) tick(1'b1, outstanding);
    if (occ > 0 || outstanding) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout occ=%0d outstanding=%0d required=0", occ, outstanding);
    end
    tick(1'b0, 1'b0);
  endtask

  // Monitor: request/completion ordering and request stability under stall.
  initial begin : monitor
    bit stall = 0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_be;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) stall = 0;
      else begin
        if (stall) begin
          chk("stall_valid", 64'(dc_req_valid), 64'd1);
          chk("stall_fields", {dc_addr, dc_be, dc_data[27:0]}, {h_addr, h_be, h_data[27:0]});
        end
        if (dc_req_valid && dc_req_ready) begin
          if (exp_req.size() == 0) chk("spurious_req", 64'(dc_addr), 64'hDEAD);
          else begin
            e = exp_req.pop_front();
            chk("dc_addr", 64'(dc_addr), 64'(e.addr));
            chk("dc_data", 64'(dc_data), 64'(e.data));
            chk("dc_be", 64'(dc_be), 64'(e.be));
          end
        end
        if (cmp_valid) begin
          if (exp_cmp.size() == 0) chk("spurious_cmp", 64'(cmp_store_pos), 64'hDEAD);
          else begin
            e = exp_cmp.pop_front();
            chk("cmp_store_pos", 64'(cmp_store_pos), 64'(e.pos));
          end
        end
        stall = dc_req_valid && !dc_req_ready;
        h_addr = dc_addr;
        h_data = dc_data;
        h_be = dc_be;
      end
    end
  end

  initial begin
    ret_addr = '0;
    ret_data = '0;
    ret_size = '0;
    ret_store_pos = '0;
    do_reset();

    // Byte store, including retire-to-request latency.
    set_lane(0, 32'h1003, 32'hAB, 2'd0, 4'd3);
    tick(1'b0, 1'b0);
    chk("lat_e0", 64'(dc_req_valid), 64'd0);
    tick(1'b0, 1'b0);
    chk("lat_e1", 64'(dc_req_valid), 64'd1);
    chk("byte_fields", {dc_addr, dc_data}, {32'h1000, 32'hAB00_0000});
    chk("byte_be", 64'(dc_be), 64'h8);
    drain();

    // Dual retire.
    set_lane(0, 32'h2000, 32'h1122_3344, 2'd2, 4'd1);
    set_lane(1, 32'h2006, 32'h0000_BEEF, 2'd1, 4'd2);
    tick(1'b0, 1'b0);
    drain();

    // Backpressure with a stray ack while requesting.
    set_lane(0, 32'h4004, 32'hCAFE_F00D, 2'd2, 4'd5);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, k == 2);
    drain();

    // Full buffer, pop and push together, wrap.
    set_lane(0, 32'h5000, 32'h1, 2'd2, 4'd1);
    set_lane(1, 32'h5004, 32'h2, 2'd2, 4'd2);
    tick(1'b0, 1'b0);
    set_lane(0, 32'h5008, 32'h3, 2'd2, 4'd3);
    set_lane(1, 32'h500C, 32'h4, 2'd2, 4'd4);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    set_lane(0, 32'h5010, 32'h5, 2'd2, 4'd5);
    set_lane(1, 32'h5014, 32'h6, 2'd2, 4'd6);
    tick(1'b0, 1'b1);
    chk("full_ovf", 64'(overflow_err), 64'd1);
    drain();

    // Misaligned word.
    set_lane(0, 32'h3002, 32'h89AB_CDEF, 2'd2, 4'd7);
    tick(1'b0, 1'b0);
    chk("mis_set", 64'(misalign_err), 64'd1);
    drain();

    // Reset while a write is outstanding; the late ack must vanish.
    set_lane(0, 32'h6000, 32'h77, 2'd0, 4'd4);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      int nv;
      nv = $urandom_range(N_WAY, 0);
      for (int l = 0; l < nv; l++)
        set_lane(l, $urandom, $urandom, 2'($urandom_range(3, 0)), 4'($urandom_range(N_SQ, 1)));
      tick(1'($urandom_range(1, 0)),
           outstanding ? 1'($urandom_range(1, 0)) : ($urandom_range(9, 0) == 0));
    end
    drain();
    chk("req_q_empty", 64'(exp_req.size()), 64'd0);
    chk("cmp_q_empty", 64'(exp_cmp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
